ring_phase_checker: RTL and testbench

- Sits directly downstream of the one-hot rotating ring counter (4-bit, reset value 0001, rotates left by one bit per clock).
- Samples the ring word and converts it to a binary phase index.
- Checks one-hot legality and rotation order, and counts full revolutions.
- Flags faults as single-cycle pulses plus a sticky error, for debug and for a system health register.

---
 rtl/ring_phase_checker.sv | 210 +++++++++++++++++++++
 tb/tb_ring_phase_checker.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_phase_checker.sv
// ring_phase_checker
//   Watches a one-hot rotating ring counter. Each accepted sample is checked
//   for one-hot legality and for rotation order, and full revolutions are
//   counted. Faults raise single-cycle pulses plus a sticky flag and a
//   saturating error count.
//
// Ports
//   clk         rising-edge clock, shared with the ring counter
//   reset       asynchronous active-high reset, clears all state
//   ring_in     ring counter word (WIDTH bits)
//   ring_vld    ring_in is sampled on this edge when high
//   clr_err     synchronous clear of the error state, returns FSM to IDLE
//   phase_idx   binary index of the set bit in the last accepted sample
//   phase_ok    high while the FSM is in TRACK
//   rev_pulse   one-cycle pulse on each wrap from bit WIDTH-1 to bit 0
//   rev_count   revolution count, wraps modulo 2^REV_W
//   err_onehot  one-cycle pulse: sample had zero or several bits set
//   err_seq     one-cycle pulse: legal sample arrived out of order
//   err_sticky  set on any error, held until clr_err or reset
//   err_count   saturating count of error events
//
// All outputs are registered: the response to a sample appears on the
// cycle after the sampling edge.

module ring_phase_checker #(
  parameter  int WIDTH = 4,
  parameter  int REV_W = 8,
  parameter  int ERR_W = 4,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             ring_vld,
  input  logic             clr_err,
  output logic [IDX_W-1:0] phase_idx,
  output logic             phase_ok,
  output logic             rev_pulse,
  output logic [REV_W-1:0] rev_count,
  output logic             err_onehot,
  output logic             err_seq,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [REV_W-1:0] ONE_REV = {{(REV_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ONE_ERR = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic is_onehot(input logic [WIDTH-1:0] word);
    return (word != {WIDTH{1'b0}}) && ((word & (word - ONE_W)) == {WIDTH{1'b0}});
  endfunction

  // Binary index of the set bit; only meaningful for a one-hot word.
  function automatic logic [IDX_W-1:0] encode(input logic [WIDTH-1:0] word);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (word[i]) begin
        idx = i[IDX_W-1:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] prev_r;

  logic             legal_s;
  logic             next_ok_s;
  logic             hold_ok_s;
  logic             accept_s;
  logic             oh_ev_s;
  logic             seq_ev_s;
  logic             rev_ev_s;
  logic             err_ev_s;

  logic [WIDTH-1:0] prev_nxt_s;
  logic [IDX_W-1:0] phase_idx_nxt_s;
  logic [REV_W-1:0] rev_count_nxt_s;
  logic             err_sticky_nxt_s;
  logic [ERR_W-1:0] err_count_nxt_s;

  assign legal_s   = is_onehot(ring_in);
  assign next_ok_s = (ring_in == {prev_r[WIDTH-2:0], prev_r[WIDTH-1]});
  assign hold_ok_s = (ring_in == prev_r);
  assign err_ev_s  = oh_ev_s | seq_ev_s;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and per-sample event decode; clr_err overrides any sample.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    oh_ev_s     = 1'b0;
    seq_ev_s    = 1'b0;
    rev_ev_s    = 1'b0;
    if (clr_err) begin
      state_nxt_s = IDLE;
    end else if (ring_vld) begin
      case (state_r)
        IDLE: begin
          if (legal_s) begin
            accept_s    = 1'b1;
            state_nxt_s = TRACK;
          end else begin
            oh_ev_s     = 1'b1;
            state_nxt_s = ERROR;
          end
        end
        TRACK: begin
          if (!legal_s) begin
            oh_ev_s     = 1'b1;
            state_nxt_s = ERROR;
          end else if (next_ok_s || hold_ok_s) begin
            accept_s = 1'b1;
            // A wrap is a true step out of the top bit, not a pause on it.
            rev_ev_s = next_ok_s & prev_r[WIDTH-1];
          end else begin
            seq_ev_s    = 1'b1;
            state_nxt_s = ERROR;
          end
        end
        ERROR: begin
          state_nxt_s = ERROR;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Next values for the registered outputs and the previous-sample word.
  always_comb begin
    prev_nxt_s       = prev_r;
    phase_idx_nxt_s  = phase_idx;
    rev_count_nxt_s  = rev_count;
    err_sticky_nxt_s = err_sticky;
    err_count_nxt_s  = err_count;
    if (accept_s) begin
      prev_nxt_s      = ring_in;
      phase_idx_nxt_s = encode(ring_in);
    end else begin
      prev_nxt_s      = prev_r;
      phase_idx_nxt_s = phase_idx;
    end
    if (rev_ev_s) begin
      rev_count_nxt_s = rev_count + ONE_REV;
    end else begin
      rev_count_nxt_s = rev_count;
    end
    if (clr_err) begin
      err_sticky_nxt_s = 1'b0;
      err_count_nxt_s  = {ERR_W{1'b0}};
    end else if (err_ev_s) begin
      err_sticky_nxt_s = 1'b1;
      err_count_nxt_s  = (err_count == ERR_MAX) ? ERR_MAX : (err_count + ONE_ERR);
    end else begin
      err_sticky_nxt_s = err_sticky;
      err_count_nxt_s  = err_count;
    end
  end

  // Output and history registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_r     <= {WIDTH{1'b0}};
      phase_idx  <= {IDX_W{1'b0}};
      phase_ok   <= 1'b0;
      rev_pulse  <= 1'b0;
      rev_count  <= {REV_W{1'b0}};
      err_onehot <= 1'b0;
      err_seq    <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= {ERR_W{1'b0}};
    end else begin
      prev_r     <= prev_nxt_s;
      phase_idx  <= phase_idx_nxt_s;
      phase_ok   <= (state_nxt_s == TRACK);
      rev_pulse  <= rev_ev_s;
      rev_count  <= rev_count_nxt_s;
      err_onehot <= oh_ev_s;
      err_seq    <= seq_ev_s;
      err_sticky <= err_sticky_nxt_s;
      err_count  <= err_count_nxt_s;
    end
  end

endmodule

// File: tb/tb_ring_phase_checker.sv
module tb_ring_phase_checker;

  localparam int WIDTH = 4;
  localparam int REV_W = 8;
  localparam int ERR_W = 4;

  typedef logic [18:0] vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] ring_in;
  logic             ring_vld;
  logic             clr_err;
  logic [1:0]       phase_idx;
  logic             phase_ok;
  logic             rev_pulse;
  logic [REV_W-1:0] rev_count;
  logic             err_onehot;
  logic             err_seq;
  logic             err_sticky;
  logic [ERR_W-1:0] err_count;

  int checks = 0;
  int errors = 0;

  vec_t exp_q[$];

  // Reference model state: 0 = idle, 1 = track, 2 = error
  int         m_state;
  logic [3:0] m_prev;
  logic [1:0] m_idx;
  logic       m_ok, m_rp, m_eoh, m_eseq, m_sticky;
  logic [7:0] m_rev;
  logic [3:0] m_cnt;

  ring_phase_checker #(.WIDTH(WIDTH), .REV_W(REV_W), .ERR_W(ERR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .ring_in    (ring_in),
    .ring_vld   (ring_vld),
    .clr_err    (clr_err),
    .phase_idx  (phase_idx),
    .phase_ok   (phase_ok),
    .rev_pulse  (rev_pulse),
    .rev_count  (rev_count),
    .err_onehot (err_onehot),
    .err_seq    (err_seq),
    .err_sticky (err_sticky),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t observed();
    return {phase_idx, phase_ok, rev_pulse, rev_count, err_onehot, err_seq, err_sticky, err_count};
  endfunction

  function automatic vec_t model_vec();
    return {m_idx, m_ok, m_rp, m_rev, m_eoh, m_eseq, m_sticky, m_cnt};
  endfunction

  task automatic model_reset();
    m_state = 0; m_prev = 4'b0000; m_idx = 2'd0; m_ok = 1'b0; m_rp = 1'b0;
    m_eoh = 1'b0; m_eseq = 1'b0; m_sticky = 1'b0; m_rev = 8'd0; m_cnt = 4'd0;
  endtask

  task automatic model_error();
    m_state  = 2;
    m_sticky = 1'b1;
    if (m_cnt != 4'd15) m_cnt = m_cnt + 4'd1;
  endtask

  task automatic model_step(input logic v, input logic [3:0] r, input logic c);
    int   ones;
    int   pos;
    logic [3:0] rot;
    m_rp = 1'b0; m_eoh = 1'b0; m_eseq = 1'b0;
    ones = 0; pos = 0;
    for (int i = 0; i < 4; i++) if (r[i]) begin ones++; pos = i; end
    rot = {m_prev[2:0], m_prev[3]};
    if (c) begin
      m_state = 0; m_sticky = 1'b0; m_cnt = 4'd0;
    end else if (v) begin
      if (m_state == 0) begin
        if (ones == 1) begin m_prev = r; m_idx = 2'(pos); m_state = 1; end
        else begin m_eoh = 1'b1; model_error(); end
      end else if (m_state == 1) begin
        if (ones != 1) begin
          m_eoh = 1'b1; model_error();
        end else if (r == rot) begin
          if (m_prev[3]) begin m_rp = 1'b1; m_rev = m_rev + 8'd1; end
          m_prev = r; m_idx = 2'(pos);
        end else if (r == m_prev) begin
          m_idx = 2'(pos);
        end else begin
          m_eseq = 1'b1; model_error();
        end
      end
    end
    m_ok = (m_state == 1);
  endtask

  // Drive one cycle of stimulus, push the model's expectation, wait for the output.
  task automatic drive(input logic v, input logic [3:0] r, input logic c);
    ring_vld = v; ring_in = r; clr_err = c;
    model_step(v, r, c);
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; ring_vld = 1'b0; ring_in = 4'b0000; clr_err = 1'b0;
    model_reset();
    exp_q.delete();
    #3;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    vec_t got;
    apply_reset();
    got = observed();
    checks++;
    if (got !== model_vec()) begin
      errors++;
      $display("FAIL reset: got %h expected %h", got, model_vec());
    end
    checks++;
    if (got !== 19'd0) begin
      errors++;
      $display("FAIL reset_zero: got %h expected %h", got, 19'd0);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] seq [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [1:0] idx [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    vec_t exp, got;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, seq[i], 1'b0);
      exp = exp_q.pop_front(); got = observed();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rotation[%0d]: got %h expected %h", i, got, exp);
      end
      checks++;
      if ({phase_idx, phase_ok, rev_pulse} !== {idx[i], 1'b1, (i == 4)}) begin
        errors++;
        $display("FAIL rotation_idx[%0d]: got %b expected %b", i,
                 {phase_idx, phase_ok, rev_pulse}, {idx[i], 1'b1, (i == 4)});
      end
    end
    checks++;
    if ({rev_count, err_sticky, err_count} !== {8'd1, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL rotation_end: got rev=%0d sticky=%b cnt=%0d expected rev=1 sticky=0 cnt=0",
               rev_count, err_sticky, err_count);
    end
  endtask

  task automatic test_hold();
    logic [3:0] seq [6] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100};
    logic       vld [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vec_t exp, got;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(vld[i], seq[i], 1'b0);
      exp = exp_q.pop_front(); got = observed();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL hold[%0d]: got %h expected %h", i, got, exp);
      end
    end
    checks++;
    if ({phase_idx, phase_ok, err_sticky} !== {2'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL hold_end: got idx=%0d ok=%b sticky=%b expected idx=2 ok=1 sticky=0",
               phase_idx, phase_ok, err_sticky);
    end
  endtask

  task automatic test_seq_error();
    logic [3:0] seq [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0011};
    vec_t exp, got;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, seq[i], 1'b0);
      exp = exp_q.pop_front(); got = observed();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL seq_error[%0d]: got %h expected %h", i, got, exp);
      end
      if (i == 2) begin
        checks++;
        if ({err_seq, err_onehot, err_sticky, err_count, phase_ok, phase_idx} !==
            {1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 2'd1}) begin
          errors++;
          $display("FAIL seq_error_pulse: got seq=%b oh=%b sticky=%b cnt=%0d ok=%b idx=%0d",
                   err_seq, err_onehot, err_sticky, err_count, phase_ok, phase_idx);
        end
      end
    end
    checks++;
    if ({err_seq, err_onehot, err_count} !== {1'b0, 1'b0, 4'd1}) begin
      errors++;
      $display("FAIL seq_error_ignored: got seq=%b oh=%b cnt=%0d expected 0 0 1",
               err_seq, err_onehot, err_count);
    end
  endtask

  task automatic test_onehot_error();
    logic [3:0] seq [3] = '{4'b0000, 4'b0000, 4'b0110};
    logic       clr [3] = '{1'b0, 1'b1, 1'b0};
    logic       oh  [3] = '{1'b1, 1'b0, 1'b1};
    vec_t exp, got;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(~clr[i], seq[i], clr[i]);
      exp = exp_q.pop_front(); got = observed();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL onehot_error[%0d]: got %h expected %h", i, got, exp);
      end
      checks++;
      if (err_onehot !== oh[i]) begin
        errors++;
        $display("FAIL onehot_pulse[%0d]: got %b expected %b", i, err_onehot, oh[i]);
      end
    end
    checks++;
    if ({err_sticky, err_count, phase_ok} !== {1'b1, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL onehot_end: got sticky=%b cnt=%0d ok=%b expected 1 1 0",
               err_sticky, err_count, phase_ok);
    end
  endtask

  task automatic test_clr_with_sample();
    logic [3:0] seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b0100};
    logic       clr [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vec_t exp, got;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, seq[i], clr[i]);
      exp = exp_q.pop_front(); got = observed();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL clr_sample[%0d]: got %h expected %h", i, got, exp);
      end
      if (i == 6) begin
        checks++;
        if ({phase_ok, rev_pulse, err_onehot, err_seq, phase_idx, rev_count} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 8'd1}) begin
          errors++;
          $display("FAIL clr_ignore: got ok=%b rp=%b oh=%b seq=%b idx=%0d rev=%0d",
                   phase_ok, rev_pulse, err_onehot, err_seq, phase_idx, rev_count);
        end
      end
    end
    checks++;
    if ({phase_ok, phase_idx, rev_count} !== {1'b1, 2'd2, 8'd1}) begin
      errors++;
      $display("FAIL clr_resume: got ok=%b idx=%0d rev=%0d expected 1 2 1",
               phase_ok, phase_idx, rev_count);
    end
  endtask

  task automatic test_revolutions();
    logic [3:0] r;
    vec_t exp, got;
    int   mism;
    logic saw_255;
    apply_reset();
    // Into the 100th revolution, then an asynchronous reset mid-cycle.
    r = 4'b0001;
    mism = 0;
    for (int n = 0; n < 399; n++) begin
      drive(1'b1, r, 1'b0);
      exp = exp_q.pop_front(); got = observed();
      checks++;
      if (got !== exp) begin
        errors++; mism++;
        if (mism < 5) $display("FAIL rev_run[%0d]: got %h expected %h", n, got, exp);
      end
      r = {r[2:0], r[3]};
    end
    checks++;
    if (rev_count !== 8'd99) begin
      errors++;
      $display("FAIL rev_before_reset: got %0d expected 99", rev_count);
    end
    #2;
    reset = 1'b1; ring_vld = 1'b0;
    model_reset();
    #1;
    got = observed();
    checks++;
    if (got !== 19'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", got, 19'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    // 256 full revolutions from a fresh start: count wraps 255 -> 0.
    r = 4'b0001;
    saw_255 = 1'b0;
    for (int n = 0; n < 1025; n++) begin
      drive(1'b1, r, 1'b0);
      exp = exp_q.pop_front(); got = observed();
      checks++;
      if (got !== exp) begin
        errors++; mism++;
        if (mism < 10) $display("FAIL rev_wrap_run[%0d]: got %h expected %h", n, got, exp);
      end
      if (rev_count == 8'd255) saw_255 = 1'b1;
      r = {r[2:0], r[3]};
    end
    checks++;
    if ({saw_255, rev_count, rev_pulse, err_sticky} !== {1'b1, 8'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rev_wrap: got saw255=%b rev=%0d rp=%b sticky=%b expected 1 0 1 0",
               saw_255, rev_count, rev_pulse, err_sticky);
    end
  endtask

  initial begin
    reset = 1'b1; ring_vld = 1'b0; ring_in = 4'b0000; clr_err = 1'b0;
    model_reset();
    test_reset();
    test_rotation();
    test_hold();
    test_seq_error();
    test_onehot_error();
    test_clr_with_sample();
    test_revolutions();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
